// File: rtl/cam_frame_capture.sv
// rtl/cam_frame_capture.sv - DVP camera capture into N-way frame buffers; optional CAM_CAPTURE_STATS_EN
// Assembles 1- or 2-byte pixels, validates frame geometry, and commits a buffer only after a well-formed frame.
module cam_frame_capture #(
    parameter int BYTES_PER_PIX = 2,
    parameter int PIX_W         = 15,
    parameter int IMG_W         = 64,
    parameter int IMG_H         = 48,
    parameter int NUM_BUF       = 2,
    parameter int ADDR_W        = 13,
    parameter int BUF_W         = 1
) (
    input  logic              pclk,
    input  logic              rst,
    input  logic              vsync,
    input  logic              href,
    input  logic [7:0]        cam_data,
    input  logic              cap_en,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [PIX_W-1:0]  wr_data,
    output logic [BUF_W-1:0]  buf_sel,
    output logic [BUF_W-1:0]  rd_buf,
    output logic              frame_start,
    output logic              frame_done,
    output logic              frame_err
`ifdef CAM_CAPTURE_STATS_EN
    ,
    output logic [15:0]       good_cnt,
    output logic [15:0]       err_cnt
`endif
);

    localparam int COL_W = $clog2(IMG_W + 1);
    localparam int ROW_W = $clog2(IMG_H + 1);
    localparam logic [COL_W-1:0]  COL_MAX     = COL_W'(IMG_W);
    localparam logic [ROW_W-1:0]  ROW_MAX     = ROW_W'(IMG_H);
    localparam logic [ADDR_W-1:0] FRAME_WORDS = ADDR_W'(IMG_W * IMG_H);
    localparam logic [ADDR_W-1:0] LINE_WORDS  = ADDR_W'(IMG_W);
    localparam logic [BUF_W-1:0]  LAST_BUF    = BUF_W'(NUM_BUF - 1);
    localparam logic              PHASE_LAST  = 1'(BYTES_PER_PIX - 1);

    typedef enum logic [1:0] {IDLE, SKIP, CAPTURE} state_t;

    state_t            state;
    logic              vs_q;
    logic              line_q;
    logic              phase;
    logic              err_flag;
    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  row;
    logic [PIX_W-1:0]  pixel;
    logic [ADDR_W-1:0] pix_addr;

    wire frame_begin = vs_q & ~vsync;
    wire frame_end   = ~vs_q & vsync;
    wire line_act    = ~vsync & href;
    wire line_fall   = line_q & ~line_act;
    wire last_byte   = (phase == PHASE_LAST);

    assign pix_addr = ADDR_W'(buf_sel) * FRAME_WORDS + ADDR_W'(row) * LINE_WORDS + ADDR_W'(col);

    generate
        if (BYTES_PER_PIX == 1) begin : g_one_byte
            assign pixel = PIX_W'(cam_data);
        end else begin : g_two_byte
            // Most significant byte arrives first and is held until its partner.
            logic [7:0] hi_byte;
            always_ff @(posedge pclk or posedge rst) begin
                if (rst) begin
                    hi_byte <= '0;
                end else if (state == CAPTURE && line_act) begin
                    hi_byte <= cam_data;
                end
            end
            assign pixel = PIX_W'({hi_byte, cam_data});
        end
    endgenerate

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            vs_q        <= 1'b0;
            line_q      <= 1'b0;
            phase       <= 1'b0;
            err_flag    <= 1'b0;
            col         <= '0;
            row         <= '0;
            wr_en       <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            buf_sel     <= '0;
            rd_buf      <= LAST_BUF;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            frame_err   <= 1'b0;
`ifdef CAM_CAPTURE_STATS_EN
            good_cnt    <= '0;
            err_cnt     <= '0;
`endif
        end else begin
            vs_q        <= vsync;
            line_q      <= line_act;
            wr_en       <= 1'b0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            frame_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (frame_begin) begin
                        if (cap_en) begin
                            state       <= CAPTURE;
                            frame_start <= 1'b1;
                            row         <= '0;
                            col         <= '0;
                            phase       <= 1'b0;
                            err_flag    <= 1'b0;
                        end else begin
                            state <= SKIP;
                        end
                    end
                end
                SKIP: begin
                    if (frame_end) state <= IDLE;
                end
                CAPTURE: begin
                    if (frame_end) begin
                        state <= IDLE;
                        if (row == ROW_MAX && !err_flag) begin
                            frame_done <= 1'b1;
                            rd_buf     <= buf_sel;
                            buf_sel    <= (buf_sel == LAST_BUF) ? '0 : buf_sel + BUF_W'(1);
`ifdef CAM_CAPTURE_STATS_EN
                            good_cnt   <= good_cnt + 16'd1;
`endif
                        end else begin
                            // Rejected frame: keep buf_sel so the next frame overwrites it.
                            frame_err  <= 1'b1;
`ifdef CAM_CAPTURE_STATS_EN
                            err_cnt    <= err_cnt + 16'd1;
`endif
                        end
                    end else if (line_act) begin
                        phase <= last_byte ? 1'b0 : phase + 1'b1;
                        if (last_byte) begin
                            if (col < COL_MAX && row < ROW_MAX) begin
                                wr_en   <= 1'b1;
                                wr_addr <= pix_addr;
                                wr_data <= pixel;
                            end else begin
                                err_flag <= 1'b1;
                            end
                            if (col < COL_MAX) col <= col + COL_W'(1);
                        end
                    end else if (line_fall) begin
                        if (col != COL_MAX || phase != 1'b0) err_flag <= 1'b1;
                        if (row < ROW_MAX) row <= row + ROW_W'(1);
                        col   <= '0;
                        phase <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cam_frame_capture.sv
// tb/tb_cam_frame_capture.sv - self-checking bench for cam_frame_capture (2-byte and 1-byte pixel instances)
module tb_cam_frame_capture;

    localparam int IMG_W   = 4;
    localparam int IMG_H   = 3;
    localparam int NUM_BUF = 2;
    localparam int ADDR_W  = 5;
    localparam int BUF_W   = 1;

    logic pclk = 1'b0;
    logic rst = 1'b1;
    logic vsync = 1'b1;
    logic href = 1'b0;
    logic cap_en = 1'b0;
    logic [7:0] cam_data = 8'd0;

    logic              we0, we1;
    logic [ADDR_W-1:0] addr0, addr1;
    logic [14:0]       data0;
    logic [7:0]        data1;
    logic [BUF_W-1:0]  bs0, bs1, rb0, rb1;
    logic              fs0, fs1, fd0, fd1, fe0, fe1;
`ifdef CAM_CAPTURE_STATS_EN
    logic [15:0]       gc0, gc1, ec0, ec1;
`endif

    always #5 pclk = ~pclk;

    cam_frame_capture #(
        .BYTES_PER_PIX(2), .PIX_W(15), .IMG_W(IMG_W), .IMG_H(IMG_H),
        .NUM_BUF(NUM_BUF), .ADDR_W(ADDR_W), .BUF_W(BUF_W)
    ) u_dut2 (
        .pclk(pclk), .rst(rst), .vsync(vsync), .href(href), .cam_data(cam_data),
        .cap_en(cap_en), .wr_en(we0), .wr_addr(addr0), .wr_data(data0),
        .buf_sel(bs0), .rd_buf(rb0), .frame_start(fs0), .frame_done(fd0), .frame_err(fe0)
`ifdef CAM_CAPTURE_STATS_EN
        , .good_cnt(gc0), .err_cnt(ec0)
`endif
    );

    cam_frame_capture #(
        .BYTES_PER_PIX(1), .PIX_W(8), .IMG_W(IMG_W), .IMG_H(IMG_H),
        .NUM_BUF(NUM_BUF), .ADDR_W(ADDR_W), .BUF_W(BUF_W)
    ) u_dut1 (
        .pclk(pclk), .rst(rst), .vsync(vsync), .href(href), .cam_data(cam_data),
        .cap_en(cap_en), .wr_en(we1), .wr_addr(addr1), .wr_data(data1),
        .buf_sel(bs1), .rd_buf(rb1), .frame_start(fs1), .frame_done(fd1), .frame_err(fe1)
`ifdef CAM_CAPTURE_STATS_EN
        , .good_cnt(gc1), .err_cnt(ec1)
`endif
    );

    int act0[$];
    int act1[$];
    int n_fs[2];
    int n_fd[2];
    int n_fe[2];
    int consec = 0;
    logic prev_we0 = 1'b0;

    always @(negedge pclk) begin
        if (we0) act0.push_back(int'(addr0) * 65536 + int'(data0));
        if (we1) act1.push_back(int'(addr1) * 65536 + int'(data1));
        if (we0 && prev_we0) consec++;
        prev_we0 = we0;
        if (fs0) n_fs[0]++;
        if (fs1) n_fs[1]++;
        if (fd0) n_fd[0]++;
        if (fd1) n_fd[1]++;
        if (fe0) n_fe[0]++;
        if (fe1) n_fe[1]++;
    end

    int total = 0;
    int bad = 0;

    int mbuf[2];
    int mrd[2];
    int mgood[2];
    int merr[2];
    int exp0[$];
    int exp1[$];
    int line_len[4];
    int fb[4][12];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick;
        @(posedge pclk);
        #1;
    endtask

    task automatic set_lens(input int a, input int b, input int c, input int d);
        line_len[0] = a;
        line_len[1] = b;
        line_len[2] = c;
        line_len[3] = d;
    endtask

    // Reference: a frame is good iff it has IMG_H lines of exactly IMG_W pixels;
    // any pixel inside the IMG_W x IMG_H window is stored at buf*W*H + line*W + pixel.
    task automatic model_frame(input int k, input int nl, input bit cap, input int rst_line,
                               output bit e_start, output bit e_done, output bit e_err);
        int bpp;
        int v;
        int a;
        bit ok;
        bit cut;
        bpp = (k == 0) ? 2 : 1;
        ok = (nl == IMG_H);
        cut = 1'b0;
        e_start = cap;
        e_done = 1'b0;
        e_err = 1'b0;
        if (!cap) return;
        for (int l = 0; l < nl && !cut; l++) begin
            if (line_len[l] != IMG_W * bpp) ok = 1'b0;
            for (int p = 0; p < line_len[l] / bpp; p++) begin
                if (l == rst_line && p * bpp + bpp - 1 >= 3) begin
                    cut = 1'b1;
                    break;
                end
                v = (bpp == 2) ? (fb[l][2*p] * 256 + fb[l][2*p+1]) % 32768 : fb[l][p];
                if (p < IMG_W && l < IMG_H) begin
                    a = mbuf[k] * IMG_W * IMG_H + l * IMG_W + p;
                    if (k == 0) exp0.push_back(a * 65536 + v);
                    else        exp1.push_back(a * 65536 + v);
                end
            end
        end
        if (rst_line >= 0) begin
            mbuf[k] = 0;
            mrd[k] = NUM_BUF - 1;
            mgood[k] = 0;
            merr[k] = 0;
        end else if (ok) begin
            e_done = 1'b1;
            mgood[k]++;
            mrd[k] = mbuf[k];
            mbuf[k] = (mbuf[k] + 1) % NUM_BUF;
        end else begin
            e_err = 1'b1;
            merr[k]++;
        end
    endtask

    task automatic run_frame(input int nl, input bit cap, input int rst_line, input bit fixed);
        bit s0, d0, e0, s1, d1, e1;
        int base0, base1;
        int fsb[2], fdb[2], feb[2];
        for (int l = 0; l < nl; l++)
            for (int b = 0; b < line_len[l]; b++)
                fb[l][b] = fixed ? ((b % 2 == 0) ? 165 : 60) : int'($urandom_range(0, 255));
        base0 = act0.size();
        base1 = act1.size();
        fsb = n_fs;
        fdb = n_fd;
        feb = n_fe;
        exp0.delete();
        exp1.delete();
        model_frame(0, nl, cap, rst_line, s0, d0, e0);
        model_frame(1, nl, cap, rst_line, s1, d1, e1);

        cap_en = cap;
        vsync = 1'b0;
        tick;
        chk("frame_start0", fs0, s0);
        chk("frame_start1", fs1, s1);
        tick;
        for (int l = 0; l < nl; l++) begin
            href = 1'b1;
            for (int b = 0; b < line_len[l]; b++) begin
                cam_data = 8'(fb[l][b]);
                tick;
                if (l == rst_line && b == 3) begin
                    rst = 1'b1;
                    #1;
                    chk("rst_wr_en0", we0, 0);
                    chk("rst_wr_en1", we1, 0);
                    chk("rst_buf_sel0", bs0, 0);
                    chk("rst_rd_buf0", rb0, NUM_BUF - 1);
                    chk("rst_rd_buf1", rb1, NUM_BUF - 1);
                end
                if (l == rst_line && b == 5) rst = 1'b0;
            end
            href = 1'b0;
            cam_data = 8'd0;
            if (l == 0) cap_en = ~cap_en;
            repeat (3) tick;
        end
        vsync = 1'b1;
        tick;
        chk("frame_done0", fd0, d0);
        chk("frame_err0", fe0, e0);
        chk("buf_sel0", bs0, mbuf[0]);
        chk("rd_buf0", rb0, mrd[0]);
        chk("frame_done1", fd1, d1);
        chk("frame_err1", fe1, e1);
        chk("buf_sel1", bs1, mbuf[1]);
        chk("rd_buf1", rb1, mrd[1]);
        href = 1'b1;
        cam_data = 8'h5A;
        repeat (2) tick;
        href = 1'b0;
        repeat (3) tick;

        chk("wr_count0", act0.size() - base0, exp0.size());
        chk("wr_count1", act1.size() - base1, exp1.size());
        for (int i = 0; i < exp0.size(); i++)
            if (base0 + i < act0.size()) chk("wr_entry0", act0[base0 + i], exp0[i]);
        for (int i = 0; i < exp1.size(); i++)
            if (base1 + i < act1.size()) chk("wr_entry1", act1[base1 + i], exp1[i]);
        chk("n_start0", n_fs[0] - fsb[0], s0);
        chk("n_done0", n_fd[0] - fdb[0], d0);
        chk("n_err0", n_fe[0] - feb[0], e0);
        chk("n_start1", n_fs[1] - fsb[1], s1);
        chk("n_done1", n_fd[1] - fdb[1], d1);
        chk("n_err1", n_fe[1] - feb[1], e1);
    endtask

    initial begin
        int nl;
        int len_tab[6];
        len_tab = '{8, 8, 8, 4, 6, 9};
        for (int k = 0; k < 2; k++) begin
            mbuf[k] = 0;
            mrd[k] = NUM_BUF - 1;
            mgood[k] = 0;
            merr[k] = 0;
        end
        repeat (3) tick;
        chk("reset_wr_en", we0, 0);
        chk("reset_wr_addr", addr0, 0);
        chk("reset_wr_data", data0, 0);
        chk("reset_buf_sel", bs0, 0);
        chk("reset_rd_buf", rb0, NUM_BUF - 1);
        chk("reset_pulses", {fs0, fd0, fe0, fs1, fd1, fe1}, 0);
        rst = 1'b0;
        repeat (3) tick;

        set_lens(8, 8, 8, 0);
        run_frame(3, 1'b1, -1, 1'b1);
        chk("first_wr", act0[0], 32'h0000_253C);
        chk("last_addr", act0[11] / 65536, 11);
        run_frame(3, 1'b1, -1, 1'b0);
        set_lens(8, 6, 8, 0);
        run_frame(3, 1'b1, -1, 1'b0);
        set_lens(8, 8, 8, 0);
        run_frame(3, 1'b1, -1, 1'b0);
        set_lens(8, 8, 9, 0);
        run_frame(3, 1'b1, -1, 1'b0);
        set_lens(8, 8, 8, 8);
        run_frame(4, 1'b1, -1, 1'b0);
        set_lens(8, 8, 8, 0);
        run_frame(3, 1'b0, -1, 1'b0);
        run_frame(3, 1'b1, -1, 1'b0);
        run_frame(3, 1'b1, 1, 1'b0);
        run_frame(3, 1'b1, -1, 1'b0);
        set_lens(4, 4, 4, 0);
        run_frame(3, 1'b1, -1, 1'b0);

        repeat (8) begin
            nl = ($urandom_range(0, 3) == 0) ? 4 : 3;
            for (int l = 0; l < 4; l++) line_len[l] = len_tab[$urandom_range(0, 5)];
            run_frame(nl, $urandom_range(0, 4) != 0, -1, 1'b0);
        end

        chk("no_back_to_back_wr", consec, 0);
`ifdef CAM_CAPTURE_STATS_EN
        chk("good_cnt0", gc0, mgood[0]);
        chk("err_cnt0", ec0, merr[0]);
        chk("good_cnt1", gc1, mgood[1]);
        chk("err_cnt1", ec1, merr[1]);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
